reg_bank_arbiter: RTL and testbench

- Shares one bank of NREG 16-bit Register instances between two requesters, e.g. the control unit (req0) and the debug/DMA port (req1).
- Each register's FunSel and I inputs are driven from a common bus; each register has its own enable bit.
- Round-robin arbitration picks one request per transaction and drives a one-hot E and a registered FunSel/I.
- Also sequences a compound two-cycle "split load" that builds a 16-bit value through the byte-write modes.

---
 rtl/reg_bank_arbiter_pkg.sv | 43 ++++
 rtl/reg_bank_arbiter_if.sv | 34 +++
 rtl/reg_bank_arbiter_rr_arbiter2.sv | 28 ++
 rtl/reg_bank_arbiter.sv | 139 +++++++++++++
 tb/tb_reg_bank_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared op-code, FunSel and state encodings for the register-bank arbiter.
// Also holds the op-to-FunSel mapping.
package reg_bank_arbiter_pkg;

    localparam logic [3:0] OP_DEC     = 4'd0;
    localparam logic [3:0] OP_INC     = 4'd1;
    localparam logic [3:0] OP_LOAD    = 4'd2;
    localparam logic [3:0] OP_CLEAR   = 4'd3;
    localparam logic [3:0] OP_LO_ZX   = 4'd4;
    localparam logic [3:0] OP_LO_KEEP = 4'd5;
    localparam logic [3:0] OP_HI      = 4'd6;
    localparam logic [3:0] OP_LO_SX   = 4'd7;
    localparam logic [3:0] OP_SPLIT   = 4'd8;

    localparam logic [2:0] FS_DEC     = 3'b000;
    localparam logic [2:0] FS_INC     = 3'b001;
    localparam logic [2:0] FS_LOAD    = 3'b010;
    localparam logic [2:0] FS_CLR     = 3'b011;
    localparam logic [2:0] FS_LO_ZX   = 3'b100;
    localparam logic [2:0] FS_LO_KEEP = 3'b101;
    localparam logic [2:0] FS_HI      = 3'b110;
    localparam logic [2:0] FS_LO_SX   = 3'b111;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_SPLIT_HI = 1'b1
    } state_t;

    function automatic logic [2:0] op_to_fs(input logic [3:0] op);
        case (op)
            OP_DEC:     return FS_DEC;
            OP_INC:     return FS_INC;
            OP_LOAD:    return FS_LOAD;
            OP_CLEAR:   return FS_CLR;
            OP_LO_ZX:   return FS_LO_ZX;
            OP_LO_KEEP: return FS_LO_KEEP;
            OP_HI:      return FS_HI;
            OP_LO_SX:   return FS_LO_SX;
            default:    return FS_DEC;
        endcase
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester handshake plus shared bank drive (FunSel/I/E) for reg_bank_arbiter.
// master = requester/bank side, slave = arbiter side.
interface reg_bank_arbiter_if
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NREG  = 4,
    parameter int SEL_W = 2
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req0_op;
    logic [3:0]       req1_op;
    logic [SEL_W-1:0] req0_sel;
    logic [SEL_W-1:0] req1_sel;
    logic [15:0]      req0_data;
    logic [15:0]      req1_data;
    logic [2:0]       FunSel;
    logic [15:0]      I;
    logic [NREG-1:0]  E;
    logic             done;
    logic             done_id;
    logic             busy;

    modport master (
        output req_valid, req0_op, req1_op, req0_sel, req1_sel, req0_data, req1_data,
        input  req_ready, FunSel, I, E, done, done_id, busy
    );

    modport slave (
        input  req_valid, req0_op, req1_op, req0_sel, req1_sel, req0_data, req1_data,
        output req_ready, FunSel, I, E, done, done_id, busy
    );

endinterface

// File: rtl/reg_bank_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; the pointer moves to the non-granted
// requester after every grant, so a lone winner also hands priority over.
module rr_arbiter2
    import reg_bank_arbiter_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic ptr_q;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
            else                grant = valid;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset)        ptr_q <= 1'b0;
        else if (|grant)  ptr_q <= grant[0];
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter driving a shared register bank (FunSel/I/one-hot E),
// including the two-beat SPLIT load. Optional macro: REG_BANK_ARBITER_ERR_EN.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int NREG  = 4,
    parameter int SEL_W = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    reg_bank_arbiter_if.slave bus
`ifdef REG_BANK_ARBITER_ERR_EN
    ,
    output logic             err_illegal
`endif
);

    state_t           state_q, state_n;
    logic             arb_en;
    logic [1:0]       grant;
    logic             acc;
    logic             win;
    logic [3:0]       op_w;
    logic [SEL_W-1:0] sel_w;
    logic [15:0]      data_w;
    logic [NREG-1:0]  e_dec;

    logic [2:0]       fs_p1, fs_n;
    logic [15:0]      i_p1, i_n;
    logic [NREG-1:0]  e_p1, e_n;
    logic             done_p1, done_n;
    logic             id_p1, id_n;
    logic [7:0]       hi_p1;

    assign arb_en = (state_q == ST_IDLE);

    rr_arbiter2 u_arb (
        .Clock (Clock),
        .Reset (Reset),
        .en    (arb_en),
        .valid (bus.req_valid),
        .grant (grant)
    );

    assign bus.req_ready = grant;
    assign acc    = |grant;
    assign win    = grant[1];
    assign op_w   = win ? bus.req1_op   : bus.req0_op;
    assign sel_w  = win ? bus.req1_sel  : bus.req0_sel;
    assign data_w = win ? bus.req1_data : bus.req0_data;

    // Out-of-range indices match no bit, leaving E all-zero.
    always_comb begin
        e_dec = '0;
        for (int k = 0; k < NREG; k++) begin
            if (int'(sel_w) == k) e_dec[k] = 1'b1;
        end
    end

    always_comb begin
        state_n = state_q;
        fs_n    = fs_p1;
        i_n     = i_p1;
        e_n     = '0;
        done_n  = 1'b0;
        id_n    = id_p1;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    id_n = win;
                    if (op_w == OP_SPLIT) begin
                        fs_n    = FS_LO_KEEP;
                        i_n     = {8'h00, data_w[7:0]};
                        e_n     = e_dec;
                        state_n = ST_SPLIT_HI;
                    end else if (op_w <= OP_LO_SX) begin
                        fs_n   = op_to_fs(op_w);
                        i_n    = data_w;
                        e_n    = e_dec;
                        done_n = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            ST_SPLIT_HI: begin
                // Second beat reuses the enable latched with beat 1.
                fs_n    = FS_HI;
                i_n     = {8'h00, hi_p1};
                e_n     = e_p1;
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // ---- stage p1: bank drive registers ----
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            fs_p1   <= FS_DEC;
            i_p1    <= '0;
            e_p1    <= '0;
            done_p1 <= 1'b0;
            id_p1   <= 1'b0;
        end else begin
            state_q <= state_n;
            fs_p1   <= fs_n;
            i_p1    <= i_n;
            e_p1    <= e_n;
            done_p1 <= done_n;
            id_p1   <= id_n;
        end
    end

    always_ff @(posedge Clock) begin
        if (arb_en && acc) hi_p1 <= data_w[15:8];
    end

    assign bus.FunSel  = fs_p1;
    assign bus.I       = i_p1;
    assign bus.E       = e_p1;
    assign bus.done    = done_p1;
    assign bus.done_id = id_p1;
    assign bus.busy    = (state_q == ST_SPLIT_HI);

`ifdef REG_BANK_ARBITER_ERR_EN
    logic err_q;

    always_ff @(posedge Clock) begin
        if (Reset)                                err_q <= 1'b0;
        else if (arb_en && acc && op_w > OP_SPLIT) err_q <= 1'b1;
    end

    assign err_illegal = err_q;
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter with a behavioural model of the
// register bank fed from FunSel/I/E.
module tb_reg_bank_arbiter;
    import reg_bank_arbiter_pkg::*;

    localparam int NREG  = 4;
    localparam int SEL_W = 2;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    reg_bank_arbiter_if #(.NREG(NREG), .SEL_W(SEL_W)) bus ();

`ifdef REG_BANK_ARBITER_ERR_EN
    logic err_illegal;
    reg_bank_arbiter #(.NREG(NREG), .SEL_W(SEL_W)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus), .err_illegal(err_illegal));
`else
    reg_bank_arbiter #(.NREG(NREG), .SEL_W(SEL_W)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus));
`endif

    typedef struct packed {
        logic [2:0]      fs;
        logic [15:0]     i;
        logic [NREG-1:0] e;
        logic            done;
        logic            id;
    } beat_t;

    beat_t       exp_q[$];
    int          n_chk  = 0;
    int          n_err  = 0;
    int          n_done = 0;
    logic        m_ptr  = 1'b0;
    logic        m_busy = 1'b0;
    logic [2:0]  m_fs   = 3'b000;
    logic [15:0] m_i    = 16'h0000;
    logic [15:0] bank [NREG] = '{default: 16'h0000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Register bank model.
    always @(posedge Clock) begin
        for (int k = 0; k < NREG; k++) begin
            if (bus.E[k] === 1'b1) begin
                case (bus.FunSel)
                    3'd0: bank[k] <= bank[k] - 16'd1;
                    3'd1: bank[k] <= bank[k] + 16'd1;
                    3'd2: bank[k] <= bus.I;
                    3'd3: bank[k] <= 16'h0000;
                    3'd4: bank[k] <= {8'h00, bus.I[7:0]};
                    3'd5: bank[k] <= {bank[k][15:8], bus.I[7:0]};
                    3'd6: bank[k] <= {bus.I[7:0], bank[k][7:0]};
                    default: bank[k] <= {{8{bus.I[7]}}, bus.I[7:0]};
                endcase
            end
        end
    end

    // Output monitor: every driven beat is compared against the scoreboard.
    always @(negedge Clock) begin
        beat_t b;
        if (bus.done === 1'b1 || (|bus.E) === 1'b1) begin
            if (bus.done === 1'b1) n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(bus.E), 32'hFFFF_FFFF);
            end else begin
                b = exp_q.pop_front();
                check("FunSel",  32'(bus.FunSel),  32'(b.fs));
                check("I",       32'(bus.I),       32'(b.i));
                check("E",       32'(bus.E),       32'(b.e));
                check("done",    32'(bus.done),    32'(b.done));
                check("done_id", 32'(bus.done_id), 32'(b.id));
            end
        end
    end

    function automatic logic [NREG-1:0] onehot(input logic [SEL_W-1:0] s);
        return NREG'(1) << s;
    endfunction

    function automatic void push(input logic [2:0] fs, input logic [15:0] i,
                                 input logic [NREG-1:0] e, input logic d, input logic id);
        beat_t b;
        b = '{fs: fs, i: i, e: e, done: d, id: id};
        exp_q.push_back(b);
        m_fs = fs;
        m_i  = i;
    endfunction

    task automatic cyc(input logic v0, input logic [3:0] o0, input logic [SEL_W-1:0] s0, input logic [15:0] d0,
                       input logic v1, input logic [3:0] o1, input logic [SEL_W-1:0] s1, input logic [15:0] d1);
        logic [1:0]       g;
        logic             w;
        logic [3:0]       o;
        logic [SEL_W-1:0] s;
        logic [15:0]      d;
        @(negedge Clock);
        bus.req_valid = {v1, v0};
        bus.req0_op = o0; bus.req0_sel = s0; bus.req0_data = d0;
        bus.req1_op = o1; bus.req1_sel = s1; bus.req1_data = d1;
        #1;
        check("busy", 32'(bus.busy), 32'(m_busy));
        if (m_busy)         g = 2'b00;
        else if (v0 && v1)  g = m_ptr ? 2'b10 : 2'b01;
        else                g = {v1, v0};
        check("req_ready", 32'(bus.req_ready), 32'(g));
        m_busy = 1'b0;
        if (g != 2'b00) begin
            w = g[1];
            o = w ? o1 : o0;
            s = w ? s1 : s0;
            d = w ? d1 : d0;
            m_ptr = ~w;
            if (o == 4'd8) begin
                push(3'b101, {8'h00, d[7:0]},  onehot(s), 1'b0, w);
                push(3'b110, {8'h00, d[15:8]}, onehot(s), 1'b1, w);
                m_busy = 1'b1;
            end else if (o <= 4'd7) begin
                push(o[2:0], d, onehot(s), 1'b1, w);
            end else begin
                push(m_fs, m_i, '0, 1'b1, w);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 4'd0, '0, 16'h0, 1'b0, 4'd0, '0, 16'h0);
    endtask

    task automatic do_reset(input int n);
        @(negedge Clock);
        Reset = 1'b1;
        bus.req_valid = 2'b00;
        repeat (n) @(negedge Clock);
        Reset  = 1'b0;
        m_ptr  = 1'b0;
        m_busy = 1'b0;
        m_fs   = 3'b000;
        m_i    = 16'h0000;
        exp_q.delete();
    endtask

    int n0;

    initial begin
        bus.req_valid = 2'b00;
        bus.req0_op = '0; bus.req0_sel = '0; bus.req0_data = '0;
        bus.req1_op = '0; bus.req1_sel = '0; bus.req1_data = '0;

        // Reset state
        repeat (3) @(negedge Clock);
        #1;
        check("rst_FunSel",    32'(bus.FunSel),    32'h0);
        check("rst_I",         32'(bus.I),         32'h0);
        check("rst_E",         32'(bus.E),         32'h0);
        check("rst_done",      32'(bus.done),      32'h0);
        check("rst_done_id",   32'(bus.done_id),   32'h0);
        check("rst_busy",      32'(bus.busy),      32'h0);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
`ifdef REG_BANK_ARBITER_ERR_EN
        check("rst_err_illegal", 32'(err_illegal), 32'h0);
`endif
        Reset = 1'b0;

        // Single LOAD
        cyc(1'b1, OP_LOAD, 2'd2, 16'hABCD, 1'b0, 4'd0, 2'd0, 16'h0);
        idle(2);
        check("R2_load", 32'(bank[2]), 32'h0000_ABCD);

        // Preload R0, R1, R3
        cyc(1'b1, OP_LOAD, 2'd0, 16'h0010, 1'b0, 4'd0, 2'd0, 16'h0);
        cyc(1'b0, 4'd0, 2'd0, 16'h0, 1'b1, OP_LOAD, 2'd1, 16'h0020);
        cyc(1'b1, OP_LOAD, 2'd3, 16'hFFFF, 1'b0, 4'd0, 2'd0, 16'h0);
        idle(2);

        // Contention: grants alternate from pointer 0
        do_reset(2);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, OP_INC, 2'd0, 16'h0, 1'b1, OP_INC, 2'd1, 16'h0);
            check("grant_seq", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
        end
        idle(2);
        check("R0_inc2", 32'(bank[0]), 32'h0012);
        check("R1_inc2", 32'(bank[1]), 32'h0022);

        // SPLIT from req1 onto R3 = FFFF
        n0 = n_done;
        cyc(1'b0, 4'd0, 2'd0, 16'h0, 1'b1, OP_SPLIT, 2'd3, 16'h8012);
        idle(3);
        check("R3_split", 32'(bank[3]), 32'h8012);
        check("split_done_pulses", 32'(n_done - n0), 32'd1);

        // Back-to-back LO_SX then DEC, no bubble
        cyc(1'b1, OP_LO_SX, 2'd0, 16'h0080, 1'b0, 4'd0, 2'd0, 16'h0);
        cyc(1'b1, OP_DEC,   2'd0, 16'h0000, 1'b0, 4'd0, 2'd0, 16'h0);
        idle(1);
        check("R0_lo_sx", 32'(bank[0]), 32'hFF80);
        idle(1);
        check("R0_dec", 32'(bank[0]), 32'hFF7F);

        // Reset while the high beat is pending
        n0 = n_done;
        cyc(1'b0, 4'd0, 2'd0, 16'h0, 1'b1, OP_SPLIT, 2'd2, 16'h1234);
        @(negedge Clock);
        #1;
        check("abort_busy", 32'(bus.busy), 32'd1);
        bus.req_valid = 2'b00;
        Reset = 1'b1;
        @(negedge Clock);
        #1;
        check("abort_E",    32'(bus.E),    32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_busy_clr", 32'(bus.busy), 32'h0);
        Reset  = 1'b0;
        m_ptr  = 1'b0;
        m_busy = 1'b0;
        m_fs   = 3'b000;
        m_i    = 16'h0000;
        exp_q.delete();
        idle(2);
        check("R2_abort", 32'(bank[2]), 32'hAB34);
        check("abort_no_done", 32'(n_done - n0), 32'd0);

        // Illegal op 12 on sel 1
        n0 = n_done;
        cyc(1'b1, 4'd12, 2'd1, 16'h5A5A, 1'b0, 4'd0, 2'd0, 16'h0);
        idle(2);
        check("illegal_done", 32'(n_done - n0), 32'd1);
        check("R1_untouched", 32'(bank[1]), 32'h0022);
`ifdef REG_BANK_ARBITER_ERR_EN
        check("err_set", 32'(err_illegal), 32'd1);
        cyc(1'b1, OP_INC, 2'd1, 16'h0, 1'b0, 4'd0, 2'd0, 16'h0);
        idle(2);
        check("err_sticky", 32'(err_illegal), 32'd1);
        do_reset(1);
        #1;
        check("err_cleared", 32'(err_illegal), 32'd0);
`endif

        idle(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
